// File: rtl/imem_boot_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory boot loader.
package imem_boot_loader_pkg;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  // Frame field order: each instruction arrives high byte first.
  localparam bit HI_FIRST = 1'b1;

  typedef enum logic [2:0] {
    ST_CNT  = 3'd0,
    ST_HI   = 3'd1,
    ST_LO   = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  function automatic logic count_ok(input logic [BYTE_W-1:0] n);
    return (n != '0) && (n <= BYTE_W'(DEPTH));
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input, instruction-memory write port and core-control status of the loader.
interface imem_boot_loader_if;
  import imem_boot_loader_pkg::*;

  logic                byte_valid;
  logic [BYTE_W-1:0]   byte_data;
  logic                byte_ready;
  logic                restart;
  logic                imem_we;
  logic [ADDR_W-1:0]   imem_addr;
  logic [INSTR_W-1:0]  imem_wdata;
  logic                cpu_hold;
  logic                load_done;
  logic                load_error;

  modport master (
    output byte_valid, byte_data, restart,
    input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_error
  );

  modport slave (
    input  byte_valid, byte_data, restart,
    output byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_error
  );

endinterface

// File: rtl/imem_boot_loader_stream_byte_pair.sv
// Pairs stream bytes into instruction words with a registered one-cycle word_valid,
// and keeps the running XOR of every instruction byte.
module imem_boot_loader_stream_byte_pair
  import imem_boot_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               hi_en_i,
  input  logic               lo_en_i,
  input  logic [BYTE_W-1:0]  byte_i,
  output logic [INSTR_W-1:0] word_o,
  output logic               word_valid_o,
  output logic [BYTE_W-1:0]  csum_o
);

  logic [BYTE_W-1:0]  hi_q, hi_d;
  logic [BYTE_W-1:0]  csum_q, csum_d;
  logic [INSTR_W-1:0] word_q, word_d;
  logic               wv_q, wv_d;

  always_comb begin
    hi_d   = hi_q;
    csum_d = csum_q;
    word_d = word_q;
    wv_d   = 1'b0;
    if (clr_i) begin
      csum_d = '0;
    end
    if (hi_en_i) begin
      hi_d   = byte_i;
      csum_d = csum_q ^ byte_i;
    end
    if (lo_en_i) begin
      word_d = HI_FIRST ? {hi_q, byte_i} : {byte_i, hi_q};
      wv_d   = 1'b1;
      csum_d = csum_q ^ byte_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      csum_q <= '0;
      word_q <= '0;
      wv_q   <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      csum_q <= csum_d;
      word_q <= word_d;
      wv_q   <= wv_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = wv_q;
  assign csum_o       = csum_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a counted, checksummed byte-stream program into instruction memory and
// holds the core in reset until a complete, verified program is present.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  imem_boot_loader_if.slave    bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               ready_q, ready_d;
  logic               hold_q, hold_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               accept_c;
  logic               clr_c;
  logic               hi_en_c;
  logic               lo_en_c;
  logic [INSTR_W-1:0] word;
  logic               word_valid;
  logic [BYTE_W-1:0]  csum;

  imem_boot_loader_stream_byte_pair u_pair (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (clr_c),
    .hi_en_i      (hi_en_c),
    .lo_en_i      (lo_en_c),
    .byte_i       (bus.byte_data),
    .word_o       (word),
    .word_valid_o (word_valid),
    .csum_o       (csum)
  );

  assign accept_c = bus.byte_valid && ready_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    clr_c   = 1'b0;
    hi_en_c = 1'b0;
    lo_en_c = 1'b0;

    // Address advances once the write it labelled has been presented.
    if (word_valid) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    case (state_q)
      ST_CNT: begin
        if (accept_c) begin
          if (count_ok(bus.byte_data)) begin
            rem_d   = CNT_W'(bus.byte_data);
            addr_d  = '0;
            clr_c   = 1'b1;
            state_d = ST_HI;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_HI: begin
        if (accept_c) begin
          hi_en_c = 1'b1;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (accept_c) begin
          lo_en_c = 1'b1;
          rem_d   = rem_q - CNT_W'(1);
          state_d = (rem_q == CNT_W'(1)) ? ST_CHK : ST_HI;
        end
      end
      ST_CHK: begin
        if (accept_c) begin
          state_d = (bus.byte_data == csum) ? ST_DONE : ST_ERR;
        end
      end
      ST_DONE, ST_ERR: begin
        if (bus.restart) begin
          state_d = ST_CNT;
        end
      end
      default: state_d = ST_CNT;
    endcase

    ready_d = (state_d != ST_DONE) && (state_d != ST_ERR);
    hold_d  = (state_d != ST_DONE);
    done_d  = (state_d == ST_DONE);
    err_d   = (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CNT;
      rem_q   <= '0;
      addr_q  <= '0;
      ready_q <= 1'b1;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      ready_q <= ready_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.imem_we    = word_valid;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word;
  assign bus.cpu_hold   = hold_q;
  assign bus.load_done  = done_q;
  assign bus.load_error = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: frames are streamed in, expected writes
// are queued as bytes are sent and matched against the observed write pulses.
module tb_imem_boot_loader;
  import imem_boot_loader_pkg::*;

  typedef struct packed {
    logic [31:0]        cyc;
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_boot_loader_if bif ();

  imem_boot_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  int   cyc = 0;
  wr_t  obs_q[$];
  wr_t  exp_q[$];
  int   rd_idx = 0;
  int   total = 0;
  int   bad = 0;
  int   stalls = 0;
  logic [7:0] pay[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Every write pulse is captured with the cycle in which it appeared.
  always @(negedge clk) begin
    if (bif.imem_we === 1'b1) obs_q.push_back({32'(cyc), bif.imem_addr, bif.imem_wdata});
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic clock(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int pick_gap(input int max_gap);
    return (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
  endfunction

  function automatic logic [7:0] pay_xor();
    logic [7:0] x = 8'h00;
    foreach (pay[i]) x = x ^ pay[i];
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap, output int acc_cyc);
    logic r;
    logic acc = 1'b0;
    if (gap > 0) begin
      bif.byte_valid = 1'b0;
      clock(gap);
    end
    bif.byte_valid = 1'b1;
    bif.byte_data  = b;
    for (int i = 0; i < 50 && !acc; i++) begin
      r = bif.byte_ready;
      @(posedge clk);
      #1;
      if (r === 1'b1) acc = 1'b1;
      else stalls++;
    end
    acc_cyc = cyc;
    if (!acc) chk("accept_timeout", 32'(acc), 32'(1));
  endtask

  task automatic send_payload(input logic [7:0] n, input int max_gap);
    int c;
    send_byte(n, pick_gap(max_gap), c);
    for (int i = 0; i + 1 < pay.size(); i += 2) begin
      send_byte(pay[i], pick_gap(max_gap), c);
      send_byte(pay[i+1], pick_gap(max_gap), c);
      exp_q.push_back({32'(c), ADDR_W'(i / 2), pay[i], pay[i+1]});
    end
  endtask

  task automatic pulse_restart();
    bif.restart = 1'b1;
    clock(1);
    bif.restart = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic rdy, input logic hold,
                              input logic done, input logic err);
    chk({tag, "_ready"}, 32'(bif.byte_ready), 32'(rdy));
    chk({tag, "_hold"},  32'(bif.cpu_hold),   32'(hold));
    chk({tag, "_done"},  32'(bif.load_done),  32'(done));
    chk({tag, "_error"}, 32'(bif.load_error), 32'(err));
  endtask

  task automatic check_writes(input string tag);
    while (exp_q.size() > 0) begin
      wr_t e;
      e = exp_q.pop_front();
      if (rd_idx < obs_q.size()) begin
        chk({tag, "_addr"}, 32'(obs_q[rd_idx].addr), 32'(e.addr));
        chk({tag, "_data"}, 32'(obs_q[rd_idx].data), 32'(e.data));
        chk({tag, "_cyc"},  obs_q[rd_idx].cyc,       e.cyc);
        rd_idx++;
      end else begin
        chk({tag, "_missing"}, 32'(obs_q.size()), 32'(rd_idx + 1));
      end
    end
    chk({tag, "_extra"}, 32'(obs_q.size()), 32'(rd_idx));
  endtask

  initial begin
    int c;
    rst            = 1'b1;
    bif.byte_valid = 1'b0;
    bif.byte_data  = 8'h00;
    bif.restart    = 1'b0;
    clock(3);
    rst = 1'b0;
    check_status("reset", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("reset_we",    32'(bif.imem_we),    32'(0));
    chk("reset_addr",  32'(bif.imem_addr),  32'(0));
    chk("reset_wdata", 32'(bif.imem_wdata), 32'(0));

    // N=3 known program, checksum 77
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_payload(8'd3, 0);
    chk("t1_hold_before_csum", 32'(bif.cpu_hold), 32'(1));
    chk("t1_done_before_csum", 32'(bif.load_done), 32'(0));
    send_byte(8'h77, 0, c);
    bif.byte_valid = 1'b0;
    check_status("t1_after_csum", 1'b0, 1'b0, 1'b1, 1'b0);
    clock(2);
    check_writes("t1");

    // Illegal counts 0x00 and 0x11
    pulse_restart();
    check_status("t2_restart", 1'b1, 1'b1, 1'b0, 1'b0);
    send_byte(8'h00, 0, c);
    bif.byte_valid = 1'b0;
    clock(2);
    check_status("t2_zero", 1'b0, 1'b1, 1'b0, 1'b1);
    pulse_restart();
    send_byte(8'h11, 0, c);
    bif.byte_valid = 1'b0;
    clock(2);
    check_status("t2_big", 1'b0, 1'b1, 1'b0, 1'b1);
    check_writes("t2");

    // N=2 with wrong checksum; correct value would be 00
    pulse_restart();
    pay = '{8'hA5, 8'h5A, 8'h0F, 8'hF0};
    send_payload(8'd2, 0);
    send_byte(8'hFF, 0, c);
    bif.byte_valid = 1'b0;
    check_status("t3_bad_csum", 1'b0, 1'b1, 1'b0, 1'b1);
    clock(2);
    check_writes("t3");
    pulse_restart();
    check_status("t3_restart", 1'b1, 1'b1, 1'b0, 1'b0);

    // Full-depth program streamed with byte_valid held high
    pay.delete();
    for (int i = 0; i < 2 * int'(DEPTH); i++) pay.push_back(8'(i * 29 + 3));
    stalls = 0;
    send_payload(8'(DEPTH), 0);
    chk("t4_done_before_csum", 32'(bif.load_done), 32'(0));
    send_byte(pay_xor(), 0, c);
    bif.byte_valid = 1'b0;
    chk("t4_stalls", 32'(stalls), 32'(0));
    check_status("t4_done", 1'b0, 1'b0, 1'b1, 1'b0);
    clock(2);
    check_writes("t4");

    // Same program with random valid gaps
    pulse_restart();
    send_payload(8'(DEPTH), 3);
    send_byte(pay_xor(), pick_gap(3), c);
    bif.byte_valid = 1'b0;
    check_status("t5_done", 1'b0, 1'b0, 1'b1, 1'b0);
    clock(2);
    check_writes("t5");

    // Reset after the high byte of instruction 2 of N=4; a byte offered during reset is ignored
    pulse_restart();
    pay = '{8'h10, 8'h01, 8'h20, 8'h02, 8'h30, 8'h03, 8'h40, 8'h04};
    send_byte(8'd4, 0, c);
    send_byte(pay[0], 0, c);
    send_byte(pay[1], 0, c);
    exp_q.push_back({32'(c), ADDR_W'(0), pay[0], pay[1]});
    send_byte(pay[2], 0, c);
    rst           = 1'b1;
    bif.byte_data = 8'h05;
    clock(2);
    rst            = 1'b0;
    bif.byte_valid = 1'b0;
    check_status("t6_reset", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t6_we",    32'(bif.imem_we),    32'(0));
    chk("t6_addr",  32'(bif.imem_addr),  32'(0));
    chk("t6_wdata", 32'(bif.imem_wdata), 32'(0));
    clock(3);
    check_writes("t6_partial");
    pay = '{8'hC3, 8'h3C, 8'h12, 8'h34};
    send_payload(8'd2, 1);
    send_byte(pay_xor(), 0, c);
    bif.byte_valid = 1'b0;
    check_status("t6_fresh", 1'b0, 1'b0, 1'b1, 1'b0);
    clock(2);
    check_writes("t6_fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
